// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg
// Shared constants for the 4-digit multiplexed 7-segment display driver.
//   - Active-low segment glyphs, bit order {g,f,e,d,c,b,a}
//   - Anode patterns (active-low, bit 3 = leftmost digit)
//   - Slot indices for the digit-select sequence
// ----------------------------------------------------------------------------
package disp_pkg;

    // Hex glyphs, active-low, ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;

    // Mode letters shown in the rightmost digit
    localparam logic [6:0] SEG_R   = 7'b1001110;
    localparam logic [6:0] SEG_T   = 7'b0000111;

    // All segments dark
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Anode patterns
    localparam logic [3:0] AN_OFF  = 4'hF;
    localparam logic [3:0] AN_HI   = 4'b0111;
    localparam logic [3:0] AN_LO   = 4'b1011;
    localparam logic [3:0] AN_MODE = 4'b1110;

    // Slot indices of the digit-select sequence
    localparam logic [1:0] SLOT_HI   = 2'd0;
    localparam logic [1:0] SLOT_LO   = 2'd1;
    localparam logic [1:0] SLOT_NC   = 2'd2;
    localparam logic [1:0] SLOT_MODE = 2'd3;

endpackage

// File: rtl/hex_to_seg.sv
// ----------------------------------------------------------------------------
// hex_to_seg
// Combinational nibble to 7-segment glyph decoder (active-low segments).
// Ports:
//   nibble  in   4  hex value to display
//   seg     out  7  glyph {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module hex_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Plain lookup; every nibble value has a glyph
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// ----------------------------------------------------------------------------
// disp_scan_ctrl
// Refresh timebase and digit multiplexer for the 4-digit 7-segment display.
// Shows the last received SPI byte (tx_mode = 0) or the next transmit byte
// (tx_mode = 1) as two hex digits plus a mode letter ('r' / 't').
//
// Optional build macro: DISP_GHOST_BLANK_EN
//   When defined, the first GUARD_CYC cycles of every slot are dark to hide
//   ghosting while the segment lines settle.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 4)
//   GUARD_CYC    dark cycles at the start of each slot (< REFRESH_DIV)
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  synchronous active-low reset
//   rx_data    in   8  byte from SPI receiver
//   rx_valid   in   1  one-cycle strobe qualifying rx_data
//   tx_data    in   8  next byte queued for transmit
//   tx_mode    in   1  0 = receive display, 1 = transmit display
//   blank      in   1  1 = all digits off, timebase keeps running
//   C          out  7  segments {g,f,e,d,c,b,a}, active-low
//   AN         out  4  digit anodes, active-low, AN[3] = leftmost
//   digit_sel  out  2  current slot index
// ----------------------------------------------------------------------------
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_mode,
    input  logic       blank,
    output logic [6:0] C,
    output logic [3:0] AN,
    output logic [1:0] digit_sel
);

    localparam int PS_W = $clog2(REFRESH_DIV);
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(REFRESH_DIV - 1);
    localparam logic [PS_W-1:0] GUARD_LIM = PS_W'(GUARD_CYC);

`ifdef DISP_GHOST_BLANK_EN
    localparam logic GUARD_EN = 1'b1;
`else
    localparam logic GUARD_EN = 1'b0;
`endif

    logic [PS_W-1:0] prescaler;
    logic [7:0]      rx_latch;
    logic            slot_tick;
    logic            guard_active;
    logic [7:0]      src;
    logic [3:0]      nibble;
    logic [6:0]      glyph;
    logic [3:0]      an_next;
    logic [6:0]      c_next;

    assign slot_tick    = (prescaler == PS_LAST);
    assign guard_active = GUARD_EN && (prescaler < GUARD_LIM);
    assign src          = tx_mode ? tx_data : rx_latch;

    // One decoder shared between the two hex digits, steered by the slot
    assign nibble = (digit_sel == SLOT_HI) ? src[7:4] : src[3:0];

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (glyph)
    );

    // Refresh timebase: prescaler sets the slot length, digit_sel walks 0..3
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            digit_sel <= SLOT_HI;
        end else begin
            if (slot_tick) begin
                prescaler <= '0;
                digit_sel <= digit_sel + 2'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Holds the most recent received byte between rx_valid strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_latch <= 8'h00;
        end else if (rx_valid) begin
            rx_latch <= rx_data;
        end
    end

    // Next anode/segment pattern for the current slot; every dark case
    // forces both AN and C fully off so only one digit can ever be lit
    always_comb begin
        an_next = AN_OFF;
        c_next  = SEG_OFF;
        if (!blank && !guard_active) begin
            case (digit_sel)
                SLOT_HI: begin
                    an_next = AN_HI;
                    c_next  = glyph;
                end
                SLOT_LO: begin
                    an_next = AN_LO;
                    c_next  = glyph;
                end
                SLOT_MODE: begin
                    an_next = AN_MODE;
                    c_next  = tx_mode ? SEG_T : SEG_R;
                end
                default: begin
                    an_next = AN_OFF;
                    c_next  = SEG_OFF;
                end
            endcase
        end
    end

    // Registered pin drivers, one cycle behind the slot state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            AN <= AN_OFF;
            C  <= SEG_OFF;
        end else begin
            AN <= an_next;
            C  <= c_next;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_disp_scan_ctrl
// Self-checking bench for disp_scan_ctrl with REFRESH_DIV = 4, GUARD_CYC = 1.
// Each driven cycle pushes the expected AN/C/digit_sel onto a scoreboard
// queue; the entry is popped and compared one clock edge later.
// Honours DISP_GHOST_BLANK_EN to match the build under test.
// ----------------------------------------------------------------------------
module tb_disp_scan_ctrl;

    localparam int REFRESH_DIV = 4;
    localparam int GUARD_CYC   = 1;

`ifdef DISP_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] c;
        logic [1:0] ds;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_mode;
    logic       blank;
    logic [6:0] C;
    logic [3:0] AN;
    logic [1:0] digit_sel;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    string tag = "init";

    // Reference state of the display timebase and receive latch
    int         m_ps = 0;
    logic [1:0] m_ds = 2'd0;
    logic [7:0] m_rx = 8'h00;

    // Held inputs for plain run cycles
    logic [7:0] cur_txd = 8'h00;
    logic       cur_txm = 1'b0;
    logic       cur_blk = 1'b0;

    disp_scan_ctrl #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD_CYC   (GUARD_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_mode   (tx_mode),
        .blank     (blank),
        .C         (C),
        .AN        (AN),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    // Glyph table written out independently of the design package
    function automatic logic [6:0] expGlyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Pop the oldest expectation and compare it with the DUT pins
    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            assert (AN === e.an) else begin
                errors++;
                $error("[TB] FAIL %s AN observed=%b expected=%b", tag, AN, e.an);
            end
            checks++;
            assert (C === e.c) else begin
                errors++;
                $error("[TB] FAIL %s C observed=%b expected=%b", tag, C, e.c);
            end
            checks++;
            assert (digit_sel === e.ds) else begin
                errors++;
                $error("[TB] FAIL %s digit_sel observed=%0d expected=%0d", tag, digit_sel, e.ds);
            end
        end
        checks++;
        assert ($countones(~AN) <= 1) else begin
            errors++;
            $error("[TB] FAIL %s one_anode observed=%b expected=at_most_one_low", tag, AN);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge,
    // then let the edge happen and compare
    task automatic applyStimulus(input logic rstn_v, input logic rxv,
                                 input logic [7:0] rxd, input logic [7:0] txd,
                                 input logic txm, input logic blk);
        exp_t e;
        logic [7:0] src;
        rst_n    = rstn_v;
        rx_valid = rxv;
        rx_data  = rxd;
        tx_data  = txd;
        tx_mode  = txm;
        blank    = blk;
        e.an = 4'hF;
        e.c  = 7'h7F;
        if (!rstn_v) begin
            m_ps = 0;
            m_ds = 2'd0;
            m_rx = 8'h00;
        end else begin
            src = txm ? txd : m_rx;
            if (!blk && !(GHOST && m_ps < GUARD_CYC)) begin
                case (m_ds)
                    2'd0: begin e.an = 4'b0111; e.c = expGlyph(src[7:4]); end
                    2'd1: begin e.an = 4'b1011; e.c = expGlyph(src[3:0]); end
                    2'd3: begin e.an = 4'b1110; e.c = txm ? 7'b0000111 : 7'b1001110; end
                    default: begin e.an = 4'hF; e.c = 7'h7F; end
                endcase
            end
            if (rxv) m_rx = rxd;
            if (m_ps == REFRESH_DIV - 1) begin
                m_ps = 0;
                m_ds = m_ds + 2'd1;
            end else begin
                m_ps = m_ps + 1;
            end
        end
        e.ds = m_ds;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic tick();
        applyStimulus(1'b1, 1'b0, 8'h00, cur_txd, cur_txm, cur_blk);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tx_data = 8'h00; tx_mode = 1'b0; blank = 1'b0;

        // Reset held for three cycles, then released
        tag = "reset";
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tag = "release";
        tick();
        checks++;
        assert (AN === (GHOST ? 4'b1111 : 4'b0111)) else begin
            errors++;
            $error("[TB] FAIL first_slot AN observed=%b expected=%b", AN, GHOST ? 4'b1111 : 4'b0111);
        end
        runCycles(3);

        // Receive A5 and show it across four slots
        tag = "rx_A5";
        applyStimulus(1'b1, 1'b1, 8'hA5, cur_txd, cur_txm, cur_blk);
        runCycles(16);

        // Transmit view of 3C, then back to receive view
        tag = "tx_3C";
        cur_txd = 8'h3C; cur_txm = 1'b1;
        runCycles(16);
        tag = "back_rx";
        cur_txm = 1'b0;
        runCycles(8);

        // New byte on the last cycle of slot 0
        tag = "align_s0_last";
        for (int i = 0; i < 16; i++) begin
            if (m_ps == REFRESH_DIV - 1 && m_ds == 2'd0) break;
            tick();
        end
        tag = "rx_FF_edge";
        applyStimulus(1'b1, 1'b1, 8'hFF, cur_txd, cur_txm, cur_blk);
        runCycles(8);

        // Blank for six cycles starting mid slot 1
        tag = "align_s1_mid";
        for (int i = 0; i < 16; i++) begin
            if (m_ps == 1 && m_ds == 2'd1) break;
            tick();
        end
        tag = "blank";
        cur_blk = 1'b1;
        runCycles(6);
        tag = "unblank";
        cur_blk = 1'b0;
        runCycles(8);

        // Mixed traffic with mid-slot mode toggles and blanking
        tag = "random";
        for (int i = 0; i < 40; i++) begin
            cur_txd = 8'($urandom);
            cur_txm = ($urandom_range(0, 3) == 0) ? ~cur_txm : cur_txm;
            cur_blk = ($urandom_range(0, 7) == 0);
            applyStimulus(1'b1, $urandom_range(0, 2) == 0, 8'($urandom),
                          cur_txd, cur_txm, cur_blk);
        end
        cur_blk = 1'b0;

        // Reset in the middle of a slot
        tag = "align_mid_reset";
        for (int i = 0; i < 16; i++) begin
            if (m_ps == 2 && m_ds == 2'd1) break;
            tick();
        end
        tag = "mid_reset";
        applyStimulus(1'b0, 1'b0, 8'h00, cur_txd, cur_txm, cur_blk);
        tag = "after_reset";
        cur_txm = 1'b0;
        runCycles(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
